fifo_multichannel_clearable: RTL and testbench
==============================================

// Module: fifo_multichannel_clearable
// PURPOSE
//  Single-clock, NUM_CHANNELS-wide bank of independent FIFOs. Each channel has its own
//  clear sequencer: isolate for one cycle, then flush, with no spurious or duplicated beats.
//  Each channel also reports fill level and almost-full. Used as the same-clock companion of
//  the clearable gray CDC FIFO, e.g. per-virtual-channel buffering behind a CDC boundary.
// PARAMETERS
//  WIDTH          1   payload width; sets the default of T
//  T              logic [WIDTH-1:0]  payload type
//  NUM_CHANNELS   2   number of independent channels, >=1
//  LOG_DEPTH      3   per-channel depth is 2**LOG_DEPTH, >=1
//  ALMOST_FULL_TH 2**LOG_DEPTH-1  almost_full_o threshold, 1..2**LOG_DEPTH
// PORTS
//  clk_i            in   1                      single clock, rising edge
//  rst_ni           in   1                      asynchronous reset, active-low
//  clear_i          in   NUM_CHANNELS           per-channel synchronous clear request
//  clear_pending_o  out  NUM_CHANNELS           channel is in its clear sequence
//  data_i           in   NUM_CHANNELS x T       write payload
//  valid_i          in   NUM_CHANNELS           write valid
//  ready_o          out  NUM_CHANNELS           write ready
//  data_o           out  NUM_CHANNELS x T       read payload (head of channel)
//  valid_o          out  NUM_CHANNELS           read valid
//  ready_i          in   NUM_CHANNELS           read ready
//  usage_o          out  NUM_CHANNELS x (LOG_DEPTH+1)  entries held, 0..2**LOG_DEPTH
//  almost_full_o    out  NUM_CHANNELS           usage_o >= ALMOST_FULL_TH
// BEHAVIOUR
//  Reset: async, all channels empty, FSM=IDLE. ready_o=1, valid_o=0, usage_o=0,
//   clear_pending_o=0, almost_full_o=0, data_o='0 (storage is reset to '0).
//  Pointers: LOG_DEPTH+1 bits, binary; wrap modulo 2**(LOG_DEPTH+1).
//   full  = (wptr^rptr)=={1'b1,'0}; empty = wptr==rptr; usage_o = wptr-rptr.
//  Push when valid_i&ready_o; ready_o = !full & FSM==IDLE.
//   A push in cycle k is visible at valid_o/data_o in cycle k+1. There is no fall-through.
//  Pop when valid_o&ready_i; valid_o = !empty & FSM==IDLE.
//   data_o = mem[rptr] combinationally from storage.
//  Simultaneous push+pop: allowed when neither full nor empty; usage unchanged.
//   When full, ready_o=0 even if a pop occurs in the same cycle.
//  Channels are fully independent. No shared arbitration and no cross-channel ordering.
//  Per-channel clear FSM: IDLE -> ISOLATE -> FLUSH -> IDLE.
//   IDLE   : clear_i=1 -> ISOLATE. A handshake in the cycle clear_i rises still completes.
//   ISOLATE: 1 cycle. ready_o=0, valid_o=0; no push or pop -> FLUSH.
//   FLUSH  : 1 cycle. ready_o=0, valid_o=0; wptr and rptr <= 0 at the cycle end -> IDLE.
//   clear_pending_o = (FSM!=IDLE).
//   clear_i while not IDLE is ignored; it is not queued.
//   clear_i rising in cycle k gives: ISOLATE in k+1, FLUSH in k+2, IDLE/empty in k+3.
//   ready_o=1 again in k+3.
//  Storage contents are not cleared by FLUSH; only the pointers reset.
//  data_o is don't-care while valid_o=0.
//  rst_ni assertion mid-sequence or mid-transfer: immediate return to the reset state.
//  almost_full_o and usage_o are combinational from the pointers.
//   During ISOLATE they hold the pre-clear level; in the cycle after FLUSH they read 0.
//  Elaboration $error if LOG_DEPTH<1, NUM_CHANNELS<1, or ALMOST_FULL_TH is out of range.
// TESTING
//  1 LOG_DEPTH=2, ch0: push A,B,C,D back-to-back, ready_i=0 -> ready_o=0 after D;
//    usage=4; almost_full from usage 3; pops return A,B,C,D in order.
//  2 Full ch0 with ready_i=1 and valid_i=1 held -> one pop, then ready_o=1 next cycle;
//    usage stays 4 after the refill, with no lost or duplicated beat.
//  3 ch1 holds 3 entries, clear_i pulse in cycle 10 -> clear_pending_o=1 in 11-12;
//    valid_o/ready_o=0 in 11-12; usage=0 in 13; ready_o=1 in 13.
//  4 clear_i on ch0 in the same cycle as a pop handshake -> the pop completes
//    (rptr advances); ch1 traffic is unaffected in every cycle.
//  5 clear_i re-pulsed in the ISOLATE cycle -> ignored; the sequence still ends
//    in cycle k+3 and no second sequence starts.
//  6 rst_ni low for 1 ns mid-FLUSH with 2 entries -> all outputs reach reset values
//    immediately; the first push after release is visible at valid_o one cycle later.

Source files
------------

// File: rtl/fifo_multichannel_clearable.sv
// Bank of independent single-clock FIFOs, one per channel, each with its own
// isolate-then-flush clear sequencer, fill level and almost-full flag.
module fifo_multichannel_clearable #(
  parameter int  WIDTH          = 1,
  parameter type T              = logic [WIDTH-1:0],
  parameter int  NUM_CHANNELS   = 2,
  parameter int  LOG_DEPTH      = 3,
  parameter int  ALMOST_FULL_TH = 2**LOG_DEPTH-1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NUM_CHANNELS-1:0]               clear_i,
  output logic [NUM_CHANNELS-1:0]               clear_pending_o,
  input  T     [NUM_CHANNELS-1:0]               data_i,
  input  logic [NUM_CHANNELS-1:0]               valid_i,
  output logic [NUM_CHANNELS-1:0]               ready_o,
  output T     [NUM_CHANNELS-1:0]               data_o,
  output logic [NUM_CHANNELS-1:0]               valid_o,
  input  logic [NUM_CHANNELS-1:0]               ready_i,
  output logic [NUM_CHANNELS-1:0][LOG_DEPTH:0]  usage_o,
  output logic [NUM_CHANNELS-1:0]               almost_full_o
);

  localparam int unsigned DEPTH = 2**LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] AF_TH    = (LOG_DEPTH+1)'(ALMOST_FULL_TH);
  localparam logic [LOG_DEPTH:0] PTR_ONE  = {{LOG_DEPTH{1'b0}}, 1'b1};
  localparam logic [LOG_DEPTH:0] PTR_FULL = {1'b1, {LOG_DEPTH{1'b0}}};

  if (LOG_DEPTH < 1 || NUM_CHANNELS < 1 ||
      ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > 2**LOG_DEPTH) begin : g_param_err
    $error("fifo_multichannel_clearable: illegal LOG_DEPTH/NUM_CHANNELS/ALMOST_FULL_TH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISOLATE,
    S_FLUSH
  } state_e;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    state_e             r_state;
    state_e             w_state_nxt;
    logic [LOG_DEPTH:0] r_wptr;
    logic [LOG_DEPTH:0] r_rptr;
    T                   r_mem [DEPTH];
    logic               w_full;
    logic               w_empty;
    logic               w_ready;
    logic               w_valid;
    logic               w_pending;
    logic               w_push;
    logic               w_pop;
    logic [LOG_DEPTH:0] w_usage;

    assign w_full  = (r_wptr ^ r_rptr) == PTR_FULL;
    assign w_empty = r_wptr == r_rptr;
    assign w_usage = r_wptr - r_rptr;
    assign w_push  = valid_i[c] & w_ready;
    assign w_pop   = w_valid & ready_i[c];

    always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_valid     = 1'b0;
      w_pending   = 1'b1;
      unique case (r_state)
        S_IDLE: begin
          w_ready   = !w_full;
          w_valid   = !w_empty;
          w_pending = 1'b0;
          if (clear_i[c]) w_state_nxt = S_ISOLATE;
        end
        S_ISOLATE: w_state_nxt = S_FLUSH;
        S_FLUSH:   w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_state <= S_IDLE;
        r_wptr  <= '0;
        r_rptr  <= '0;
      end else begin
        r_state <= w_state_nxt;
        // Handshakes are already gated to IDLE, so FLUSH only needs the pointer reset.
        if (r_state == S_FLUSH) begin
          r_wptr <= '0;
          r_rptr <= '0;
        end else begin
          if (w_push) r_wptr <= r_wptr + PTR_ONE;
          if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
        r_mem[r_wptr[LOG_DEPTH-1:0]] <= data_i[c];
      end
    end

    assign ready_o[c]         = w_ready;
    assign valid_o[c]         = w_valid;
    assign clear_pending_o[c] = w_pending;
    assign data_o[c]          = r_mem[r_rptr[LOG_DEPTH-1:0]];
    assign usage_o[c]         = w_usage;
    assign almost_full_o[c]   = w_usage >= AF_TH;
  end

endmodule

// File: tb/tb_fifo_multichannel_clearable.sv
// Directed plus random bench for fifo_multichannel_clearable, checked against a
// queue-based model of each channel and its clear sequence.
module tb_fifo_multichannel_clearable;

  localparam int NCH   = 2;
  localparam int LOGD  = 2;
  localparam int DEPTH = 4;
  localparam int AFTH  = 3;

  logic                       clk_i = 1'b0;
  logic                       rst_ni = 1'b0;
  logic [NCH-1:0]             clear_i = '0;
  logic [NCH-1:0]             clear_pending_o;
  logic [NCH-1:0][7:0]        data_i = '0;
  logic [NCH-1:0]             valid_i = '0;
  logic [NCH-1:0]             ready_o;
  logic [NCH-1:0][7:0]        data_o;
  logic [NCH-1:0]             valid_o;
  logic [NCH-1:0]             ready_i = '0;
  logic [NCH-1:0][LOGD:0]     usage_o;
  logic [NCH-1:0]             almost_full_o;

  int checks = 0;
  int errors = 0;

  // Model: contents per channel plus clear phase (0 idle, 1 isolate, 2 flush).
  logic [7:0] mq [NCH][$];
  int         mclr [NCH];

  fifo_multichannel_clearable #(
    .WIDTH(8),
    .NUM_CHANNELS(NCH),
    .LOG_DEPTH(LOGD),
    .ALMOST_FULL_TH(AFTH)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .clear_i(clear_i),
    .clear_pending_o(clear_pending_o),
    .data_i(data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_o(data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .usage_o(usage_o),
    .almost_full_o(almost_full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready(int c);
    return mq[c].size() < DEPTH && mclr[c] == 0;
  endfunction

  function automatic bit m_valid(int c);
    return mq[c].size() > 0 && mclr[c] == 0;
  endfunction

  task automatic check_all();
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("ready%0d", c),   ready_o[c],         m_ready(c));
      chk($sformatf("valid%0d", c),   valid_o[c],         m_valid(c));
      chk($sformatf("usage%0d", c),   usage_o[c],         mq[c].size());
      chk($sformatf("afull%0d", c),   almost_full_o[c],   mq[c].size() >= AFTH);
      chk($sformatf("pending%0d", c), clear_pending_o[c], mclr[c] != 0);
      if (m_valid(c)) chk($sformatf("data%0d", c), data_o[c], mq[c][0]);
    end
  endtask

  task automatic model_update();
    logic [7:0] dummy;
    bit pop, push;
    for (int c = 0; c < NCH; c++) begin
      if (mclr[c] == 0) begin
        pop  = m_valid(c) && ready_i[c];
        push = m_ready(c) && valid_i[c];
        if (pop)  dummy = mq[c].pop_front();
        if (push) mq[c].push_back(data_i[c]);
        if (clear_i[c]) mclr[c] = 1;
      end else if (mclr[c] == 1) begin
        mclr[c] = 2;
      end else begin
        mq[c].delete();
        mclr[c] = 0;
      end
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      mclr[c] = 0;
    end
  endtask

  // Entered at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic step();
    #2;
    check_all();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  initial begin
    model_reset();
    #3;
    check_all();
    chk("rst_data0", data_o[0], 8'h00);
    chk("rst_data1", data_o[1], 8'h00);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Fill ch0 without draining, then drain in order.
    for (int i = 0; i < 4; i++) begin
      valid_i = 2'b01;
      data_i[0] = 8'hA0 + 8'(i);
      step();
    end
    valid_i = '0;
    chk("t1_ready_full", ready_o[0], 1'b0);
    chk("t1_usage4", usage_o[0], 4);
    chk("t1_afull", almost_full_o[0], 1'b1);
    ready_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      chk("t1_pop_order", data_o[0], 8'hA0 + 8'(i));
      step();
    end
    ready_i = '0;
    chk("t1_empty", valid_o[0], 1'b0);

    // Full with both handshakes requested: only the pop happens.
    for (int i = 0; i < 4; i++) begin
      valid_i = 2'b01;
      data_i[0] = 8'hB0 + 8'(i);
      step();
    end
    ready_i = 2'b01;
    data_i[0] = 8'hC0;
    chk("t2_full_noready", ready_o[0], 1'b0);
    step();
    chk("t2_ready_back", ready_o[0], 1'b1);
    chk("t2_usage3", usage_o[0], 3);
    ready_i = '0;
    data_i[0] = 8'hC1;
    step();
    chk("t2_usage4", usage_o[0], 4);
    valid_i = '0;
    ready_i = 2'b01;
    for (int i = 0; i < 4; i++) step();
    ready_i = '0;

    // ch1 clear with three entries.
    for (int i = 0; i < 3; i++) begin
      valid_i = 2'b10;
      data_i[1] = 8'hD0 + 8'(i);
      step();
    end
    valid_i = '0;
    clear_i = 2'b10;
    step();
    clear_i = '0;
    chk("t3_pend_k1", clear_pending_o[1], 1'b1);
    chk("t3_valid_k1", valid_o[1], 1'b0);
    chk("t3_usage_iso", usage_o[1], 3);
    step();
    chk("t3_pend_k2", clear_pending_o[1], 1'b1);
    chk("t3_ready_k2", ready_o[1], 1'b0);
    step();
    chk("t3_pend_k3", clear_pending_o[1], 1'b0);
    chk("t3_usage_k3", usage_o[1], 0);
    chk("t3_ready_k3", ready_o[1], 1'b1);
    step();

    // ch0 clear coinciding with a pop; ch1 keeps random traffic.
    for (int i = 0; i < 2; i++) begin
      valid_i = 2'b01 | {1'($urandom), 1'b0};
      ready_i = {1'($urandom), 1'b0};
      data_i[0] = 8'hE0 + 8'(i);
      data_i[1] = 8'($urandom);
      step();
    end
    valid_i = {1'($urandom), 1'b0};
    ready_i = 2'b01 | {1'($urandom), 1'b0};
    data_i[1] = 8'($urandom);
    clear_i = 2'b01;
    step();
    clear_i = '0;
    chk("t4_pop_done", usage_o[0], 1);
    for (int i = 0; i < 4; i++) begin
      valid_i = {1'($urandom), 1'b0};
      ready_i = {1'($urandom), 1'b0};
      data_i[1] = 8'($urandom);
      step();
    end
    valid_i = '0;
    ready_i = '0;

    // Clear re-pulsed during ISOLATE is ignored.
    for (int i = 0; i < 2; i++) begin
      valid_i = 2'b01;
      data_i[0] = 8'h50 + 8'(i);
      step();
    end
    valid_i = '0;
    clear_i = 2'b01;
    step();
    step();
    clear_i = '0;
    step();
    chk("t5_idle_k3", clear_pending_o[0], 1'b0);
    step();
    chk("t5_no_second", clear_pending_o[0], 1'b0);
    step();

    // Async reset pulse in the middle of FLUSH.
    for (int i = 0; i < 2; i++) begin
      valid_i = 2'b01;
      data_i[0] = 8'h60 + 8'(i);
      step();
    end
    valid_i = '0;
    clear_i = 2'b01;
    step();
    clear_i = '0;
    step();
    chk("t6_in_flush", clear_pending_o[0], 1'b1);
    #1 rst_ni = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_rst_data", data_o[0], 8'h00);
    rst_ni = 1'b1;
    valid_i = 2'b01;
    data_i[0] = 8'h77;
    step();
    valid_i = '0;
    chk("t6_first_valid", valid_o[0], 1'b1);
    chk("t6_first_data", data_o[0], 8'h77);
    step();

    // Random traffic on both channels.
    for (int n = 0; n < 400; n++) begin
      valid_i = 2'($urandom);
      ready_i = 2'($urandom);
      data_i[0] = 8'($urandom);
      data_i[1] = 8'($urandom);
      for (int c = 0; c < NCH; c++) clear_i[c] = ($urandom_range(0, 19) == 0);
      step();
    end
    clear_i = '0;
    valid_i = '0;
    ready_i = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
